memory_stage: RTL and testbench
===============================

# memory_stage

Memory stage of the Y86-64 pipeline. It consumes the M-register fields produced by the execute-to-memory pipeline register and performs the data-memory access: synchronous write, combinational little-endian 8-byte read. It computes destination registers and the post-memory status, then registers the result into the W (writeback) pipeline register. It also exposes combinational valM and status for forwarding and pipeline control.

## Interface
Parameters:
- MEM_BYTES, 1024: data-memory size in bytes; valid addresses are 0..MEM_BYTES-1.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stat_m  in  3  M-stage status (AOK=1, HLT=2, ADR=3, INS=4)
- icode_m, ifun_m  in  4 each  M-stage instruction code/function
- rA_m, rB_m  in  4 each  register IDs (RNONE=15)
- cnd_m  in  1  condition result from execute
- valA_m, valB_m, valc_m, valp_m, valE_m  in  64 each  M-stage operands
- W_stall  in  1  hold W register
- W_bubble  in  1  load nop into W register
- valM_m  out  64  combinational memory read data (forwarding)
- stat_mem  out  3  combinational post-memory status
- stat_w  out  3  registered status
- icode_w  out  4  registered icode
- valE_w, valM_w  out  64 each  registered results
- dstE_w, dstM_w  out  4 each  registered destination registers

## Operation
- Address: valE_m for rmmovq(4), mrmovq(5), pushq(A), call(8); valA_m for popq(B), ret(9).
- Read when icode is 5, B, or 9. Write when icode is 4 or A (data valA_m), or 8 (data valp_m).
- Data layout: little-endian; byte addr holds bits [7:0], addr+7 holds bits [63:56].
- mem_error: an access is active and addr > MEM_BYTES-8. Compute the comparison in 64-bit unsigned arithmetic; addresses near 2^64 must not wrap into range.
- stat_mem: ADR when mem_error, otherwise stat_m.
- valM_m: the read data when a read is active and there is no mem_error, otherwise 0.
- Write enable requires all of:
  - write icode,
  - no mem_error,
  - stat_m == AOK,
  - stat_w == AOK (an older instruction already faulted: suppress).
- dstE:
  - rB_m for irmovq(3) and OPq(6).
  - rB_m for icode 2 only when cnd_m=1, otherwise RNONE.
  - 4 (%rsp) for A, B, 8, 9.
  - RNONE otherwise.
- dstM: rA_m for 5 and B; RNONE otherwise.
- ifun_m, valB_m, valc_m are unused; they are kept for interface symmetry.

## Timing
- Memory write commits on the rising edge in the cycle the instruction occupies M. A same-cycle read of the same address returns the old data. A read in the next cycle returns the new data.
- valM_m and stat_mem are combinational from the M inputs; there is no added latency.
- W register updates on each rising edge with {stat_mem, icode_m, valE_m, valM_m, dstE, dstM}. M-to-W latency is 1 cycle.
- W_bubble=1: W loads stat=AOK, icode=1 (nop), valE=valM=0, dstE=dstM=RNONE.
- W_stall=1: W holds its value.
- Both W_stall and W_bubble asserted: bubble wins.
- Reset (rst=1 at the edge):
  - W takes the bubble values: stat_w=1, icode_w=1, valE_w=valM_w=0, dstE_w=dstM_w=15.
  - Memory writes are blocked that cycle.
  - Memory contents are not cleared.
  - Reset mid-stream discards the W contents immediately.
- While W_stall=1, writes are still governed by the write-enable rule. Control is responsible for bubbling M when W stalls.

## Structure
- Shared package/include y86_defs:
  - icode constants (IHALT..IPOPQ),
  - stat codes (SAOK, SHLT, SADR, SINS),
  - RNONE, RRSP.
- One sub-module, data_memory (MEM_BYTES byte array, 8-byte combinational read, 8-byte synchronous write, error flag). The W register and dst logic live in memory_stage.
- Expected size: about 200 lines.

## Test plan
- rmmovq: icode=4, valE=0x100, valA=0x1122334455667788. Next cycle: mrmovq icode=5, valE=0x100, rA=3. Required: valM_m=0x1122334455667788, byte 0x100=0x88. One cycle later: dstM_w=3, valM_w matches.
- call: icode=8, valE=0x3F8, valp=0x2A. Required: the write occurs. Then ret: icode=9, valA=0x3F8. Required: valM_m=0x2A, dstE_w=4.
- Bounds: mrmovq, valE=MEM_BYTES-7. Required: stat_mem=ADR and valM_m=0. Then rmmovq, valE=0xFFFFFFFFFFFFFFFC. Required: stat_mem=ADR and memory unchanged.
- Suppression:
  - Establish stat_w=ADR, then rmmovq to 0x80 with stat_m=AOK. Required: 0x80 unchanged.
  - rmmovq with stat_m=INS. Required: no write, stat_w=INS.
- cmov: icode=2, rB=5. cnd_m=0 gives dstE_w=15; cnd_m=1 gives dstE_w=5.
- Control and reset:
  - W_stall holds W for 3 cycles.
  - W_stall=W_bubble=1 gives icode_w=1.
  - rst mid-stream gives stat_w=1, icode_w=1, dstE_w=dstM_w=15.
  - A write presented during rst does not commit.

Source files
------------

// File: rtl/y86_defs.sv
// Shared Y86-64 encodings: instruction codes, status codes and register IDs,
// plus helpers classifying which instructions touch data memory.
package y86_defs;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    function automatic logic is_mem_read(input logic [3:0] icode);
        return (icode == IMRMOVQ) || (icode == IPOPQ) || (icode == IRET);
    endfunction

    function automatic logic is_mem_write(input logic [3:0] icode);
        return (icode == IRMMOVQ) || (icode == IPUSHQ) || (icode == ICALL);
    endfunction

endpackage

// File: rtl/memory_stage_data_memory.sv
// Byte-addressed data memory: 8-byte little-endian combinational read,
// 8-byte synchronous write, and an out-of-range error flag.
module data_memory
    import y86_defs::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rd_en,
    input  logic        wr_req,
    input  logic        wr_ok,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        mem_error
);

    localparam int          AW        = $clog2(MEM_BYTES);
    localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);

    logic [7:0]    mem [MEM_BYTES];
    logic [AW-1:0] base;
    logic          we;

    // Full 64-bit compare so addresses near 2^64 cannot alias into range.
    assign mem_error = (rd_en || wr_req) && (addr > LAST_ADDR);
    assign base      = mem_error ? '0 : addr[AW-1:0];
    assign we        = wr_req && wr_ok && !mem_error;

    always_comb begin
        rdata = '0;
        if (rd_en && !mem_error) begin
            for (int i = 0; i < 8; i++) begin
                rdata[8*i +: 8] = mem[base + AW'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                mem[base + AW'(i)] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: data-memory access, destination selection and the
// W pipeline register, with combinational valM/status for forwarding.
module memory_stage
    import y86_defs::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  stat_m,
    input  logic [3:0]  icode_m,
    input  logic [3:0]  ifun_m,
    input  logic [3:0]  rA_m,
    input  logic [3:0]  rB_m,
    input  logic        cnd_m,
    input  logic [63:0] valA_m,
    input  logic [63:0] valB_m,
    input  logic [63:0] valc_m,
    input  logic [63:0] valp_m,
    input  logic [63:0] valE_m,
    input  logic        W_stall,
    input  logic        W_bubble,
    output logic [63:0] valM_m,
    output logic [2:0]  stat_mem,
    output logic [2:0]  stat_w,
    output logic [3:0]  icode_w,
    output logic [63:0] valE_w,
    output logic [63:0] valM_w,
    output logic [3:0]  dstE_w,
    output logic [3:0]  dstM_w
);

    logic        rd_en;
    logic        wr_req;
    logic        wr_ok;
    logic        mem_error;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic        unused_inputs;

    assign unused_inputs = ^{ifun_m, valB_m, valc_m};

    assign rd_en     = is_mem_read(icode_m);
    assign wr_req    = is_mem_write(icode_m);
    assign mem_addr  = (icode_m == IPOPQ || icode_m == IRET) ? valA_m : valE_m;
    assign mem_wdata = (icode_m == ICALL) ? valp_m : valA_m;
    // An older faulted instruction sitting in W must block younger writes.
    assign wr_ok     = !rst && (stat_m == SAOK) && (stat_w == SAOK);

    data_memory #(.MEM_BYTES(MEM_BYTES)) u_dmem (
        .clk      (clk),
        .rd_en    (rd_en),
        .wr_req   (wr_req),
        .wr_ok    (wr_ok),
        .addr     (mem_addr),
        .wdata    (mem_wdata),
        .rdata    (valM_m),
        .mem_error(mem_error)
    );

    assign stat_mem = mem_error ? SADR : stat_m;

    always_comb begin
        dst_e = RNONE;
        case (icode_m)
            IIRMOVQ, IOPQ:               dst_e = rB_m;
            IRRMOVQ:                     dst_e = cnd_m ? rB_m : RNONE;
            IPUSHQ, IPOPQ, ICALL, IRET:  dst_e = RRSP;
            default:                     dst_e = RNONE;
        endcase
    end

    assign dst_m = (icode_m == IMRMOVQ || icode_m == IPOPQ) ? rA_m : RNONE;

    // M -> W register boundary
    always_ff @(posedge clk) begin
        if (rst || W_bubble) begin
            stat_w  <= SAOK;
            icode_w <= INOP;
            valE_w  <= '0;
            valM_w  <= '0;
            dstE_w  <= RNONE;
            dstM_w  <= RNONE;
        end else if (!W_stall) begin
            stat_w  <= stat_mem;
            icode_w <= icode_m;
            valE_w  <= valE_m;
            valM_w  <= valM_m;
            dstE_w  <= dst_e;
            dstM_w  <= dst_m;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with hand-computed expected values.
module tb_memory_stage;

    localparam int MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  stat_m;
    logic [3:0]  icode_m, ifun_m, rA_m, rB_m;
    logic        cnd_m;
    logic [63:0] valA_m, valB_m, valc_m, valp_m, valE_m;
    logic        W_stall, W_bubble;
    logic [63:0] valM_m;
    logic [2:0]  stat_mem, stat_w;
    logic [3:0]  icode_w, dstE_w, dstM_w;
    logic [63:0] valE_w, valM_w;

    int checks   = 0;
    int failures = 0;

    memory_stage #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst(rst), .stat_m(stat_m), .icode_m(icode_m), .ifun_m(ifun_m),
        .rA_m(rA_m), .rB_m(rB_m), .cnd_m(cnd_m), .valA_m(valA_m), .valB_m(valB_m),
        .valc_m(valc_m), .valp_m(valp_m), .valE_m(valE_m), .W_stall(W_stall),
        .W_bubble(W_bubble), .valM_m(valM_m), .stat_mem(stat_mem), .stat_w(stat_w),
        .icode_w(icode_w), .valE_w(valE_w), .valM_w(valM_w), .dstE_w(dstE_w),
        .dstM_w(dstM_w)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] ra,
                         input logic [3:0] rb, input logic c, input logic [63:0] va,
                         input logic [63:0] ve, input logic [63:0] vp);
        stat_m  = st;  icode_m = ic;  rA_m = ra;  rB_m = rb;  cnd_m = c;
        valA_m  = va;  valE_m  = ve;  valp_m = vp;
        #1;
    endtask

    initial begin
        rst = 1'b1; W_stall = 1'b0; W_bubble = 1'b0;
        ifun_m = 4'h0; valB_m = 64'h0; valc_m = 64'h0;
        set_m(3'd1, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 64'h0);
        step(); step();
        rst = 1'b0;
        check_eq("reset_stat_w", stat_w, 3'd1);
        check_eq("reset_icode_w", icode_w, 4'h1);
        check_eq("reset_valE_w", valE_w, 64'h0);
        check_eq("reset_valM_w", valM_w, 64'h0);
        check_eq("reset_dstE_w", dstE_w, 4'hF);
        check_eq("reset_dstM_w", dstM_w, 4'hF);

        // rmmovq then mrmovq from the same address
        set_m(3'd1, 4'h4, 4'h1, 4'h2, 1'b0, 64'h1122334455667788, 64'h100, 64'h0);
        check_eq("rmmovq_stat_mem", stat_mem, 3'd1);
        check_eq("rmmovq_valM_m", valM_m, 64'h0);
        step();
        set_m(3'd1, 4'h5, 4'h3, 4'hF, 1'b0, 64'h0, 64'h100, 64'h0);
        check_eq("mrmovq_valM_m", valM_m, 64'h1122334455667788);
        check_eq("mrmovq_byte0", {56'h0, valM_m[7:0]}, 64'h88);
        step();
        check_eq("mrmovq_dstM_w", dstM_w, 4'h3);
        check_eq("mrmovq_valM_w", valM_w, 64'h1122334455667788);
        check_eq("mrmovq_dstE_w", dstE_w, 4'hF);
        check_eq("mrmovq_icode_w", icode_w, 4'h5);

        // call writes valp at the highest legal address, ret reads it back
        set_m(3'd1, 4'h8, 4'hF, 4'hF, 1'b0, 64'h55, 64'h3F8, 64'h2A);
        check_eq("call_stat_mem", stat_mem, 3'd1);
        step();
        check_eq("call_dstE_w", dstE_w, 4'h4);
        set_m(3'd1, 4'h9, 4'hF, 4'hF, 1'b0, 64'h3F8, 64'h400, 64'h0);
        check_eq("ret_valM_m", valM_m, 64'h2A);
        step();
        check_eq("ret_dstE_w", dstE_w, 4'h4);
        check_eq("ret_valM_w", valM_w, 64'h2A);
        check_eq("ret_valE_w", valE_w, 64'h400);

        // bounds
        set_m(3'd1, 4'h5, 4'h2, 4'hF, 1'b0, 64'h0, 64'(MEM_BYTES - 7), 64'h0);
        check_eq("oob_read_stat_mem", stat_mem, 3'd3);
        check_eq("oob_read_valM_m", valM_m, 64'h0);
        step();
        check_eq("oob_read_stat_w", stat_w, 3'd3);
        W_bubble = 1'b1;
        set_m(3'd1, 4'h4, 4'h1, 4'h2, 1'b0, 64'hDEADBEEFDEADBEEF, 64'hFFFFFFFFFFFFFFFC, 64'h0);
        check_eq("oob_write_stat_mem", stat_mem, 3'd3);
        step();
        W_bubble = 1'b0;
        set_m(3'd1, 4'h5, 4'h2, 4'hF, 1'b0, 64'h0, 64'h3F8, 64'h0);
        check_eq("oob_write_mem_unchanged", valM_m, 64'h2A);
        step();

        // suppression behind a faulted W
        set_m(3'd1, 4'h4, 4'h1, 4'h2, 1'b0, 64'hCAFE, 64'h80, 64'h0);
        step();
        set_m(3'd1, 4'h5, 4'h2, 4'hF, 1'b0, 64'h0, 64'(MEM_BYTES - 7), 64'h0);
        step();
        check_eq("fault_stat_w", stat_w, 3'd3);
        set_m(3'd1, 4'h4, 4'h1, 4'h2, 1'b0, 64'h1234, 64'h80, 64'h0);
        step();
        set_m(3'd1, 4'h5, 4'h2, 4'hF, 1'b0, 64'h0, 64'h80, 64'h0);
        check_eq("suppress_statw_mem80", valM_m, 64'hCAFE);
        step();
        set_m(3'd4, 4'h4, 4'h1, 4'h2, 1'b0, 64'h9999, 64'h80, 64'h0);
        check_eq("ins_stat_mem", stat_mem, 3'd4);
        step();
        check_eq("ins_stat_w", stat_w, 3'd4);
        set_m(3'd1, 4'h5, 4'h2, 4'hF, 1'b0, 64'h0, 64'h80, 64'h0);
        check_eq("suppress_ins_mem80", valM_m, 64'hCAFE);
        step();

        // cmov
        set_m(3'd1, 4'h2, 4'h1, 4'h5, 1'b0, 64'h7, 64'h7, 64'h0);
        step();
        check_eq("cmov_nc_dstE_w", dstE_w, 4'hF);
        set_m(3'd1, 4'h2, 4'h1, 4'h5, 1'b1, 64'h7, 64'h7, 64'h0);
        step();
        check_eq("cmov_c_dstE_w", dstE_w, 4'h5);

        // stall holds W
        set_m(3'd1, 4'h3, 4'hF, 4'h6, 1'b0, 64'h0, 64'h77, 64'h0);
        step();
        check_eq("irmovq_icode_w", icode_w, 4'h3);
        check_eq("irmovq_dstE_w", dstE_w, 4'h6);
        W_stall = 1'b1;
        set_m(3'd1, 4'h6, 4'h1, 4'h2, 1'b0, 64'h0, 64'h99, 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_icode_w", icode_w, 4'h3);
            check_eq("stall_valE_w", valE_w, 64'h77);
        end
        W_bubble = 1'b1;
        step();
        check_eq("stall_bubble_icode_w", icode_w, 4'h1);
        check_eq("stall_bubble_dstE_w", dstE_w, 4'hF);
        W_stall = 1'b0; W_bubble = 1'b0;

        // reset mid-stream discards W and blocks the write
        set_m(3'd1, 4'h5, 4'h7, 4'hF, 1'b0, 64'h0, 64'h100, 64'h0);
        step();
        check_eq("pre_rst_dstM_w", dstM_w, 4'h7);
        rst = 1'b1;
        set_m(3'd1, 4'h4, 4'h1, 4'h2, 1'b0, 64'h5555, 64'h80, 64'h0);
        step();
        rst = 1'b0;
        check_eq("rst_stat_w", stat_w, 3'd1);
        check_eq("rst_icode_w", icode_w, 4'h1);
        check_eq("rst_dstE_w", dstE_w, 4'hF);
        check_eq("rst_dstM_w", dstM_w, 4'hF);
        check_eq("rst_valM_w", valM_w, 64'h0);
        set_m(3'd1, 4'h5, 4'h2, 4'hF, 1'b0, 64'h0, 64'h80, 64'h0);
        check_eq("rst_write_blocked", valM_m, 64'hCAFE);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
